// File: rtl/tff_mod_counter_pkg.sv
// rtl/tff_mod_counter_pkg.sv - shared encodings and S/R command types for toggle-based counters
package tff_mod_counter_pkg;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   localparam int SR_MAX_WIDTH = 16;

   typedef struct packed {
      logic [SR_MAX_WIDTH-1:0] s;
      logic [SR_MAX_WIDTH-1:0] r;
   } sr_cmd_t;

   typedef struct packed {
      logic s;
      logic r;
   } sr_bit_t;

   // A toggle request becomes set when the cell is low and reset when it is high,
   // so s and r can never be asserted together.
   function automatic sr_bit_t tcell_cmd(input logic t, input logic q);
      sr_bit_t cmd;
      cmd.s = t & ~q;
      cmd.r = t & q;
      return cmd;
   endfunction

endpackage

// File: rtl/tff_mod_counter_if.sv
// rtl/tff_mod_counter_if.sv - control and count signals of the modulo-N T-cell counter
interface tff_mod_counter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             wrap;

   modport master (
      output en, up, load, load_val,
      input  count, tc, wrap
   );

   modport slave (
      input  en, up, load, load_val,
      output count, tc, wrap
   );
endinterface

// File: rtl/tff_mod_counter_sr_tcell.sv
// rtl/tff_mod_counter_sr_tcell.sv - one set/reset flip-flop cell used as a T flip-flop
module sr_tcell (
   input  logic clk,
   input  logic reset,
   input  logic s,
   input  logic r,
   output logic q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= 1'b0;
      end else if (s) begin
         q <= 1'b1;
      end else if (r) begin
         q <= 1'b0;
      end
   end

endmodule

// File: rtl/tff_mod_counter.sv
// rtl/tff_mod_counter.sv - modulo-N up/down counter with load, built from S/R T-cells
module tff_mod_counter
   import tff_mod_counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic               clk,
   input  logic               reset,
   tff_mod_counter_if.slave   bus
);

   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] next_count;
   logic [WIDTH-1:0] t;
   logic             in_range;
   logic             load_ok;
   logic             wrap_next;
   logic             wrap_q;

   assign in_range = ({1'b0, q} < MOD_EXT);
   assign load_ok  = ({1'b0, bus.load_val} < MOD_EXT);

   // Reset and load go through the same toggle path as counting, so every
   // state change reaches the cells as a single S or R term.
   always_comb begin
      next_count = q;
      wrap_next  = 1'b0;
      if (reset) begin
         next_count = '0;
      end else if (bus.load) begin
         next_count = load_ok ? bus.load_val : MAX_CNT;
      end else if (bus.en) begin
         if (bus.up == DIR_UP) begin
            if (!in_range) begin
               next_count = '0;
            end else if (q == MAX_CNT) begin
               next_count = '0;
               wrap_next  = 1'b1;
            end else begin
               next_count = q + WIDTH'(1);
            end
         end else begin
            if (!in_range) begin
               next_count = MAX_CNT;
            end else if (q == '0) begin
               next_count = MAX_CNT;
               wrap_next  = 1'b1;
            end else begin
               next_count = q - WIDTH'(1);
            end
         end
      end
   end

   assign t = q ^ next_count;

   for (genvar i = 0; i < WIDTH; i++) begin : gen_cell
      sr_bit_t cmd;
      assign cmd = tcell_cmd(t[i], q[i]);

      sr_tcell u_cell (
         .clk   (clk),
         .reset (reset),
         .s     (cmd.s),
         .r     (cmd.r),
         .q     (q[i])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= wrap_next;
      end
   end

   // Decoded straight from inputs and cell outputs so it can feed the en of a
   // following stage without a register in between.
   assign bus.tc    = bus.en & ((bus.up == DIR_UP) ? (q == MAX_CNT) : (q == '0));
   assign bus.count = q;
   assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_tff_mod_counter.sv
// tb/tb_tff_mod_counter.sv - scoreboard bench for the modulo-10 T-cell counter
module tb_tff_mod_counter;
   import tff_mod_counter_pkg::*;

   typedef struct {
      logic [3:0] count;
      logic       wrap;
      logic       tc;
      string      tag;
   } exp_t;

   logic clk;
   logic reset;
   logic sr_watch;
   int   checks_total;
   int   checks_passed;
   exp_t exp_q[$];
   int   m_cnt;

   tff_mod_counter_if #(.WIDTH(4)) bus ();

   tff_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      checks_total++;
      if (act == req) begin
         checks_passed++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic drive(input logic rst, input logic en, input logic up, input logic ld,
                        input logic [3:0] lv, input int ec, input int ew, input int etc,
                        input string tag);
      exp_t e;
      @(negedge clk);
      reset        = rst;
      bus.en       = en;
      bus.up       = up;
      bus.load     = ld;
      bus.load_val = lv;
      e.count = 4'(ec);
      e.wrap  = ew[0];
      e.tc    = etc[0];
      e.tag   = tag;
      exp_q.push_back(e);
   endtask

   // Monitor: every edge that follows issued stimulus presents a new count.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.tag, ".count"}, int'(bus.count), int'(e.count));
            check({e.tag, ".wrap"},  int'(bus.wrap),  int'(e.wrap));
            check({e.tag, ".tc"},    int'(bus.tc),    int'(e.tc));
         end
      end
   end

   always @(negedge clk) begin
      if (sr_watch) begin
         check("sr_exclusive",
               int'({dut.gen_cell[3].u_cell.s & dut.gen_cell[3].u_cell.r,
                     dut.gen_cell[2].u_cell.s & dut.gen_cell[2].u_cell.r,
                     dut.gen_cell[1].u_cell.s & dut.gen_cell[1].u_cell.r,
                     dut.gen_cell[0].u_cell.s & dut.gen_cell[0].u_cell.r}), 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic r_rst, r_en, r_up, r_ld;
      logic [3:0] r_lv;
      int n_cnt, n_wrap, n_tc;

      checks_total  = 0;
      checks_passed = 0;
      sr_watch      = 1'b0;
      reset         = 1'b1;
      bus.en        = 1'b1;
      bus.up        = DIR_UP;
      bus.load      = 1'b0;
      bus.load_val  = 4'd0;

      // 1: reset with en=1, then count 1..9
      drive(1, 1, DIR_UP, 0, 4'd0, 0, 0, 0, "t1_reset0");
      drive(1, 1, DIR_UP, 0, 4'd0, 0, 0, 0, "t1_reset1");
      sr_watch = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         drive(0, 1, DIR_UP, 0, 4'd0, i, 0, (i == 9) ? 1 : 0, "t1_up");
      end
      // 2: up wrap, then 1
      drive(0, 1, DIR_UP, 0, 4'd0, 0, 1, 0, "t2_wrap");
      drive(0, 1, DIR_UP, 0, 4'd0, 1, 0, 0, "t2_after");
      // 3: down to 0, down wrap to 9, then 8,7,6
      drive(0, 1, DIR_DN, 0, 4'd0, 0, 0, 1, "t3_to0");
      drive(0, 1, DIR_DN, 0, 4'd0, 9, 1, 0, "t3_wrap");
      drive(0, 1, DIR_DN, 0, 4'd0, 8, 0, 0, "t3_dn8");
      drive(0, 1, DIR_DN, 0, 4'd0, 7, 0, 0, "t3_dn7");
      drive(0, 1, DIR_DN, 0, 4'd0, 6, 0, 0, "t3_dn6");
      // 4: saturating load beats en, then in-range load
      drive(0, 1, DIR_UP, 1, 4'd13, 9, 0, 1, "t4_sat");
      drive(0, 1, DIR_UP, 1, 4'd3,  3, 0, 0, "t4_ld3");
      // 5: reset beats load at count 5
      drive(0, 1, DIR_UP, 0, 4'd0, 4, 0, 0, "t5_to4");
      drive(0, 1, DIR_UP, 0, 4'd0, 5, 0, 0, "t5_to5");
      drive(1, 1, DIR_UP, 1, 4'd7, 0, 0, 0, "t5_rst_ld");
      drive(0, 1, DIR_UP, 0, 4'd0, 1, 0, 0, "t5_after");
      // hold, load without en, load at terminal count suppresses wrap
      drive(0, 0, DIR_UP, 0, 4'd0, 1, 0, 0, "hold");
      drive(0, 0, DIR_UP, 1, 4'd9, 9, 0, 0, "ld9_noen");
      drive(0, 1, DIR_UP, 1, 4'd0, 0, 0, 0, "ld_at_tc");
      drive(0, 1, DIR_UP, 1, 4'd10, 9, 0, 1, "ld10_sat");

      // 6: random cycles against a modulo-10 reference
      m_cnt = 9;
      for (int k = 0; k < 500; k++) begin
         r_rst = ($urandom_range(0, 49) == 0);
         r_en  = 1'($urandom_range(0, 1));
         r_up  = 1'($urandom_range(0, 1));
         r_ld  = ($urandom_range(0, 7) == 0);
         r_lv  = 4'($urandom_range(0, 15));
         n_wrap = 0;
         if (r_rst) begin
            n_cnt = 0;
         end else if (r_ld) begin
            n_cnt = (int'(r_lv) < 10) ? int'(r_lv) : 9;
         end else if (r_en) begin
            if (r_up) begin
               n_cnt  = (m_cnt + 1) % 10;
               n_wrap = (m_cnt == 9) ? 1 : 0;
            end else begin
               n_cnt  = (m_cnt + 9) % 10;
               n_wrap = (m_cnt == 0) ? 1 : 0;
            end
         end else begin
            n_cnt = m_cnt;
         end
         n_tc  = (r_en && (r_up ? (n_cnt == 9) : (n_cnt == 0))) ? 1 : 0;
         m_cnt = n_cnt;
         drive(r_rst, r_en, r_up, r_ld, r_lv, n_cnt, n_wrap, n_tc, "rand");
      end

      repeat (3) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
